jtpopeye_objdraw: RTL

Object line-buffer drawer, directly downstream of the object ROM block. It accepts one object-row draw request at a time and drives the 13-bit object ROM address. It captures the returned 32 bits (16 pixels, 2bpp) and writes the non-transparent pixels into a double-buffered 256-entry line buffer. Each line, the video side reads the other bank, erasing it as it reads.

---
 rtl/jtpopeye_obj_pkg.sv | 25 ++
 rtl/jtpopeye_objbuf.sv | 36 +++
 rtl/jtpopeye_objdraw.sv | 126 ++++++++++++
 3 files changed

// File: rtl/jtpopeye_obj_pkg.sv
// Shared encodings and constants for the object line-buffer drawer.
// obj_pixel picks one 2bpp pixel out of the captured {k,j,f,e} ROM word.
package jtpopeye_obj_pkg;

    localparam int OBJ_W      = 16;
    localparam int LINE_W     = 256;
    localparam int ROMLAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LATCH = 2'd2,
        ST_DRAW  = 2'd3
    } obj_state_t;

    // Pixels 0..7 come from {f,e} (low half), 8..15 from {k,j}; bit 7-p[2:0] in both cases.
    function automatic logic [1:0] obj_pixel(input logic [31:0] data, input logic [3:0] p);
        logic [15:0] w_sel;
        logic [2:0]  w_bit;
        w_sel = p[3] ? data[31:16] : data[15:0];
        w_bit = 3'd7 - p[2:0];
        return {w_sel[{1'b1, w_bit}], w_sel[{1'b0, w_bit}]};
    endfunction

endpackage

// File: rtl/jtpopeye_objbuf.sv
// Dual-bank object line buffer: drawing writes bank ~i_bank while the video
// side reads bank i_bank and clears each entry as it is read.
module jtpopeye_objbuf
    import jtpopeye_obj_pkg::*;
#(
    parameter int PALW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_bank,
    input  logic            i_we,
    input  logic [7:0]      i_waddr,
    input  logic [PALW+1:0] i_wdata,
    input  logic            i_pxl_cen,
    input  logic [7:0]      i_h,
    output logic [PALW+1:0] o_pxl
);

    logic [PALW+1:0] r_mem [0:2*LINE_W-1];

    // Banks never coincide, so the draw write and the erase never collide.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[{~i_bank, i_waddr}] <= i_wdata;
        if (i_pxl_cen)
            r_mem[{i_bank, i_h}] <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_pxl <= '0;
        else if (i_pxl_cen)
            o_pxl <= r_mem[{i_bank, i_h}];
    end

endmodule

// File: rtl/jtpopeye_objdraw.sv
// Object row drawer: fetches one 16-pixel object row from ROM and paints its
// opaque pixels into the hidden line-buffer bank; hs_start swaps banks.
module jtpopeye_objdraw
    import jtpopeye_obj_pkg::*;
#(
    parameter int PALW   = 3,
    parameter int ROMLAT = ROMLAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hs_start,
    input  logic [7:0]      h,
    input  logic            obj_start,
    input  logic [8:0]      obj_code,
    input  logic [3:0]      obj_row,
    input  logic [7:0]      obj_x,
    input  logic            obj_hflip,
    input  logic            obj_vflip,
    input  logic [PALW-1:0] obj_pal,
    output logic            obj_busy,
    output logic [12:0]     obj_addr,
    input  logic [15:0]     obj_dout0,
    input  logic [15:0]     obj_dout1,
    output logic [PALW+1:0] pxl_out
);

    obj_state_t      r_state, w_next;
    logic [3:0]      r_wcnt;
    logic [3:0]      r_pix;
    logic [7:0]      r_x;
    logic            r_hflip;
    logic [PALW-1:0] r_pal;
    logic [31:0]     r_data;
    logic            r_bank;

    logic            w_accept;
    logic [1:0]      w_colour;
    logic            w_we;
    logic [7:0]      w_waddr;
    logic [PALW+1:0] w_wdata;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // busy still high here means the previous draw just ended
                if (!hs_start && !obj_busy && obj_start) begin
                    w_accept = 1'b1;
                    w_next   = ST_WAIT;
                end
            end
            ST_WAIT:  if (r_wcnt == 4'(ROMLAT - 1)) w_next = ST_LATCH;
            ST_LATCH: w_next = ST_DRAW;
            ST_DRAW:  if (r_pix == 4'(OBJ_W - 1)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (hs_start)
            w_next = ST_IDLE;
    end

    always_comb begin
        w_colour = obj_pixel(r_data, r_hflip ? ~r_pix : r_pix);
        w_we     = (r_state == ST_DRAW) && !hs_start && (w_colour != 2'd0);
        w_waddr  = r_x + {4'd0, r_pix};
        w_wdata  = {r_pal, w_colour};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_pix    <= '0;
            r_x      <= '0;
            r_hflip  <= 1'b0;
            r_pal    <= '0;
            r_data   <= '0;
            r_bank   <= 1'b0;
            obj_busy <= 1'b0;
            obj_addr <= '0;
        end else begin
            if (hs_start)
                r_bank <= ~r_bank;

            if (hs_start)
                obj_busy <= 1'b0;
            else if (w_accept)
                obj_busy <= 1'b1;
            else if (r_state == ST_IDLE)
                obj_busy <= 1'b0;

            if (w_accept) begin
                obj_addr <= {obj_code, obj_row ^ {4{obj_vflip}}};
                r_x      <= obj_x;
                r_hflip  <= obj_hflip;
                r_pal    <= obj_pal;
            end

            r_wcnt <= (r_state == ST_WAIT) ? r_wcnt + 4'd1 : 4'd0;
            r_pix  <= (r_state == ST_DRAW) ? r_pix + 4'd1 : 4'd0;

            if (r_state == ST_LATCH)
                r_data <= {obj_dout0, obj_dout1};
        end
    end

    jtpopeye_objbuf #(.PALW(PALW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_bank    (r_bank),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_pxl_cen (pxl_cen),
        .i_h       (h),
        .o_pxl     (pxl_out)
    );

endmodule
